// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared state encoding and default timing constants for button_event
package button_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HELD    = 2'd2,
    ST_LOCKOUT = 2'd3
  } btn_state_t;

  localparam int HOLD_CYCLES_DEFAULT   = 50_000_000;
  localparam int REPEAT_CYCLES_DEFAULT = 10_000_000;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_event_edge_detect.sv
// rtl/button_event_edge_detect.sv - previous-sample register with rise/fall detection
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic level_in,
  output logic level_q,
  output logic rise,
  output logic fall
);

  // Track the last sample; reset loads the live level so a held button does not look like a rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= level_in;
    end else begin
      level_q <= level_in;
    end
  end

  // Edges compare the current sample against the previous one.
  always_comb begin
    rise = level_in & ~level_q;
    fall = ~level_in & level_q;
  end

endmodule

// File: rtl/button_event.sv
// rtl/button_event.sv - press/release/hold/repeat event generator for a debounced button
module button_event
  import button_pkg::*;
#(
  parameter int HOLD_CYCLES   = HOLD_CYCLES_DEFAULT,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic level_in,
  output logic press_pulse,
  output logic release_pulse,
  output logic hold_pulse,
  output logic repeat_pulse,
  output logic held
);

  // One counter serves both thresholds; it clears at each one so it never wraps.
  localparam int CNT_W = $clog2(max2(HOLD_CYCLES, REPEAT_CYCLES) + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  btn_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             level_q;
  logic             rise;
  logic             fall;

  edge_detect u_edge (
    .clk      (clk),
    .rst      (rst),
    .level_in (level_in),
    .level_q  (level_q),
    .rise     (rise),
    .fall     (fall)
  );

  // Event FSM with registered strobes; a fall is checked before any threshold so release wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      // level_q takes level_in on this same edge, so this matches "LOCKOUT if level_q=1" after reset.
      state         <= level_in ? ST_LOCKOUT : ST_IDLE;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      hold_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      held          <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      hold_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rise) begin
            state       <= ST_PRESSED;
            press_pulse <= 1'b1;
            held        <= 1'b1;
            cnt         <= '0;
          end
        end
        ST_PRESSED: begin
          if (fall) begin
            state         <= ST_IDLE;
            release_pulse <= 1'b1;
            held          <= 1'b0;
            cnt           <= '0;
          end else if (cnt == HOLD_LAST) begin
            state      <= ST_HELD;
            hold_pulse <= 1'b1;
            cnt        <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_HELD: begin
          if (fall) begin
            state         <= ST_IDLE;
            release_pulse <= 1'b1;
            held          <= 1'b0;
            cnt           <= '0;
          end else if (REPEAT_CYCLES != 0) begin
            if (cnt == REPEAT_LAST) begin
              repeat_pulse <= 1'b1;
              cnt          <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        ST_LOCKOUT: begin
          // Button was down through reset: wait for it to go up silently.
          held <= 1'b0;
          if (fall) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          held  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
